// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 decrypt datapath.
// Imported by the decrypt controller and its datapath blocks.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARK_INIT,
    S_ISR,
    S_ISB,
    S_ARK,
    S_IMC,
    S_DONE
  } aes_state_e;

  // Round key r sits at the top of the schedule for r=0.
  function automatic logic [127:0] round_key(
    input logic [1407:0] ks,
    input int            r
  );
    return ks[1407-128*r -: 128];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]}
      ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// InvAddRoundKey: state XOR round key.
module aes_add_round_key (
  input  logic [127:0] d_i,
  input  logic [127:0] k_i,
  output logic [127:0] q_o
);

  assign q_o = d_i ^ k_i;

endmodule

// File: rtl/aes_inv_mixcol_word.sv
// InvMixColumns on a single 32-bit column, purely combinational.
module aes_inv_mixcol_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;

  assign col_o[31:24] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                      ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
  assign col_o[23:16] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                      ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
  assign col_o[15:8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                      ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
  assign col_o[7:0]   = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                      ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);

endmodule

// File: rtl/aes_inv_shift_rows.sv
// InvShiftRows: row r of the 4x4 byte state rotates right by r.
// Byte (r,c) lives at state[127-8*(4c+r) -: 8].
module aes_inv_shift_rows (
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);

  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign q_o[127-8*(4*c+r) -: 8] =
        d_i[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// InvSubBytes over all 16 state bytes in parallel.
module aes_inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] d_i,
  output logic [127:0] q_o
);

  for (genvar b = 0; b < 16; b++) begin : g_b
    assign q_o[8*b +: 8] = inv_sbox(d_i[8*b +: 8]);
  end

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decrypt controller: FSM, round/column counters,
// state register and next-state mux over the shared datapath blocks.
module aes_decrypt_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS         = aes_pkg::NUM_ROUNDS,
  parameter int MIX_COLS_PER_CYCLE = 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          AES_START,
  input  logic [127:0]  AES_MSG_ENC,
  input  logic [1407:0] AES_KEY_SCHEDULE,
  output logic [127:0]  AES_MSG_DEC,
  output logic          AES_DONE,
  output logic          BUSY
);

  localparam int RW = $clog2(NUM_ROUNDS + 1);

  if (MIX_COLS_PER_CYCLE != 1) begin : g_bad_cfg
    $error("MIX_COLS_PER_CYCLE must be 1");
  end

  aes_state_e     fsm_q, fsm_d;
  logic [127:0]   state_q, state_d;
  logic [RW-1:0]  round_q, round_d;
  logic [1:0]     col_q, col_d;

  logic [127:0]   isr_w, isb_w, ark_w, rkey_w;
  logic [31:0]    col_in_w, col_out_w;
  logic [127:0]   imc_mask;
  int             key_idx;

  assign key_idx = (fsm_q == S_ARK_INIT) ? NUM_ROUNDS
                 : NUM_ROUNDS - int'(round_q);
  assign rkey_w  = round_key(AES_KEY_SCHEDULE, key_idx);

  aes_inv_shift_rows u_isr (
    .d_i (state_q),
    .q_o (isr_w)
  );

  aes_inv_sub_bytes u_isb (
    .d_i (state_q),
    .q_o (isb_w)
  );

  aes_add_round_key u_ark (
    .d_i (state_q),
    .k_i (rkey_w),
    .q_o (ark_w)
  );

  assign col_in_w = state_q[127-32*int'(col_q) -: 32];

  aes_inv_mixcol_word u_imc (
    .col_i (col_in_w),
    .col_o (col_out_w)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    col_d   = col_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (AES_START) begin
          state_d = AES_MSG_ENC;
          round_d = RW'(1);
          col_d   = '0;
          fsm_d   = S_ARK_INIT;
        end
      end
      S_ARK_INIT: begin
        state_d = ark_w;
        fsm_d   = S_ISR;
      end
      S_ISR: begin
        state_d = isr_w;
        fsm_d   = S_ISB;
      end
      S_ISB: begin
        state_d = isb_w;
        fsm_d   = S_ARK;
      end
      S_ARK: begin
        state_d = ark_w;
        fsm_d   = (round_q == RW'(NUM_ROUNDS)) ? S_DONE : S_IMC;
      end
      S_IMC: begin
        state_d[127-32*int'(col_q) -: 32] = col_out_w;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          round_d = round_q + RW'(1);
          fsm_d   = S_ISR;
        end
      end
      S_DONE: begin
        if (!AES_START) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      round_q <= '0;
      col_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      col_q   <= col_d;
    end
  end

  assign AES_MSG_DEC = state_q;
  assign AES_DONE    = (fsm_q == S_DONE);
  assign BUSY        = (fsm_q != S_IDLE) && (fsm_q != S_DONE);

  // Only the selected column may move during an IMC cycle.
  assign imc_mask = {96'h0, 32'hffff_ffff} << (32 * (3 - int'(col_q)));

  a_imc_one_col: assert property (@(posedge CLK)
    (fsm_q == S_IMC) |-> (((state_d ^ state_q) & ~imc_mask) == '0));

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed bench for aes_decrypt_ctrl using FIPS-197 vectors and an
// independent forward-cipher model for round-trip checks.
module tb_aes_decrypt_ctrl;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] F_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R_PT = 128'h3243f6a8885a308d313198a2e0370734;

  logic          CLK;
  logic          RESET_N;
  logic          AES_START;
  logic [127:0]  AES_MSG_ENC;
  logic [1407:0] AES_KEY_SCHEDULE;
  logic [127:0]  AES_MSG_DEC;
  logic          AES_DONE;
  logic          BUSY;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sbox_t [256];

  aes_decrypt_ctrl dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .AES_START        (AES_START),
    .AES_MSG_ENC      (AES_MSG_ENC),
    .AES_KEY_SCHEDULE (AES_KEY_SCHEDULE),
    .AES_MSG_DEC      (AES_MSG_DEC),
    .AES_DONE         (AES_DONE),
    .BUSY             (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    logic [7:0] s;
    s = {a[6:0], 1'b0};
    return a[7] ? (s ^ 8'h1b) : s;
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = m_xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [1407:0] m_expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ks;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]],
             sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = m_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] p, input logic [1407:0] ks);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ ks[1407-8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sbox_t[s[r][c]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = t[r][(c+r)%4];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          s[1][c] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          s[2][c] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          s[3][c] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ ks[1407-128*rnd-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && m_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[a] = b;
    end
  endtask

  // hold > 0: drop START after that many edges; hold <= 0: keep it high.
  task automatic do_run(input logic [127:0] ct, input int hold,
                        output int lat, output logic [127:0] pt,
                        output logic gap);
    AES_MSG_ENC = ct;
    AES_START   = 1'b1;
    lat = 0;
    gap = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge CLK); #1;
      AES_MSG_ENC = ~ct;
      if (hold > 0 && e >= hold) AES_START = 1'b0;
      if (AES_DONE === 1'b1) begin
        lat = e;
        break;
      end
      if (BUSY !== 1'b1) gap = 1'b1;
    end
    pt = AES_MSG_DEC;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick(2);
    n_cmp++;
    if (AES_DONE !== 1'b0) begin
      n_err++; $display("FAIL reset_done: got %b want 0", AES_DONE);
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", BUSY);
    end
    n_cmp++;
    if (AES_MSG_DEC !== 128'h0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", AES_MSG_DEC);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_fips_pulse();
    int lat; logic [127:0] pt; logic gap; int busy_hi;
    do_run(F_CT, 1, lat, pt, gap);
    n_cmp++;
    if (lat !== 68) begin
      n_err++; $display("FAIL fips_latency: got %0d want 68", lat);
    end
    n_cmp++;
    if (pt !== F_PT) begin
      n_err++; $display("FAIL fips_pt: got %h want %h", pt, F_PT);
    end
    n_cmp++;
    if (gap !== 1'b0) begin
      n_err++; $display("FAIL fips_busy_gap: got %b want 0", gap);
    end
    tick(1);
    n_cmp++;
    if (AES_DONE !== 1'b0) begin
      n_err++; $display("FAIL pulse_done_fall: got %b want 0", AES_DONE);
    end
    busy_hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (BUSY !== 1'b0) busy_hi++;
      tick(1);
    end
    n_cmp++;
    if (busy_hi !== 0) begin
      n_err++; $display("FAIL pulse_idle: got %0d busy cycles want 0", busy_hi);
    end
  endtask

  task automatic test_start_held();
    int lat; logic [127:0] pt; logic gap;
    int drops, busys, chg;
    do_run(F_CT, 0, lat, pt, gap);
    n_cmp++;
    if (lat !== 68) begin
      n_err++; $display("FAIL held_latency: got %0d want 68", lat);
    end
    n_cmp++;
    if (pt !== F_PT) begin
      n_err++; $display("FAIL held_pt: got %h want %h", pt, F_PT);
    end
    drops = 0; busys = 0; chg = 0;
    for (int i = 0; i < 132; i++) begin
      tick(1);
      if (AES_DONE !== 1'b1) drops++;
      if (BUSY !== 1'b0) busys++;
      if (AES_MSG_DEC !== F_PT) chg++;
    end
    n_cmp++;
    if (drops !== 0) begin
      n_err++; $display("FAIL held_done: got %0d low cycles want 0", drops);
    end
    n_cmp++;
    if (busys !== 0) begin
      n_err++; $display("FAIL held_retrigger: got %0d busy cycles want 0", busys);
    end
    n_cmp++;
    if (chg !== 0) begin
      n_err++; $display("FAIL held_state: got %0d changed cycles want 0", chg);
    end
    AES_START = 1'b0;
    tick(1);
    n_cmp++;
    if (AES_DONE !== 1'b0) begin
      n_err++; $display("FAIL held_done_fall: got %b want 0", AES_DONE);
    end
    tick(1);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL held_idle: got %b want 0", BUSY);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] pt; logic gap;
    AES_MSG_ENC = F_CT;
    AES_START   = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge CLK); #1;
      AES_START = 1'b0;
    end
    RESET_N = 1'b0;
    tick(1);
    n_cmp++;
    if (AES_DONE !== 1'b0) begin
      n_err++; $display("FAIL abort_done: got %b want 0", AES_DONE);
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL abort_busy: got %b want 0", BUSY);
    end
    n_cmp++;
    if (AES_MSG_DEC !== 128'h0) begin
      n_err++; $display("FAIL abort_state: got %h want 0", AES_MSG_DEC);
    end
    RESET_N = 1'b1;
    do_run(F_CT, 1, lat, pt, gap);
    n_cmp++;
    if (lat !== 68) begin
      n_err++; $display("FAIL rerun_latency: got %0d want 68", lat);
    end
    n_cmp++;
    if (pt !== F_PT) begin
      n_err++; $display("FAIL rerun_pt: got %h want %h", pt, F_PT);
    end
    tick(1);
  endtask

  task automatic test_back_to_back();
    int lat; logic [127:0] pt, re; logic gap;
    do_run(F_CT, 1, lat, pt, gap);
    n_cmp++;
    if (pt !== F_PT || lat !== 68) begin
      n_err++; $display("FAIL b2b_first: got %h lat %0d want %h lat 68", pt, lat, F_PT);
    end
    tick(1);
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_err++; $display("FAIL b2b_between: got busy %b want 0", BUSY);
    end
    do_run(128'h0, 1, lat, pt, gap);
    n_cmp++;
    if (lat !== 68) begin
      n_err++; $display("FAIL b2b_latency: got %0d want 68", lat);
    end
    re = m_encrypt(pt, AES_KEY_SCHEDULE);
    n_cmp++;
    if (re !== 128'h0) begin
      n_err++; $display("FAIL b2b_zero_ct: enc(dut)=%h want 0 (dut %h)", re, pt);
    end
    n_cmp++;
    if (gap !== 1'b0) begin
      n_err++; $display("FAIL b2b_busy_gap: got %b want 0", gap);
    end
    tick(1);
  endtask

  task automatic test_roundtrip();
    int lat; logic [127:0] pt, ct; logic gap;
    ct = m_encrypt(R_PT, AES_KEY_SCHEDULE);
    do_run(ct, 3, lat, pt, gap);
    n_cmp++;
    if (lat !== 68) begin
      n_err++; $display("FAIL rt_latency: got %0d want 68", lat);
    end
    n_cmp++;
    if (pt !== R_PT) begin
      n_err++; $display("FAIL rt_pt: got %h want %h", pt, R_PT);
    end
    tick(1);
  endtask

  initial begin
    RESET_N          = 1'b0;
    AES_START        = 1'b0;
    AES_MSG_ENC      = '0;
    AES_KEY_SCHEDULE = '0;
    build_sbox();
    AES_KEY_SCHEDULE = m_expand(KEY);
    test_reset();
    test_fips_pulse();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
